// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: programmable issue engine feeding ALU micro-ops onto the A/B/Cin/Mode bus
// Ports:
//   Clk, nReset         clock, asynchronous active-low reset
//   wr_en, wr_data      program load; entry = {Mode[12:9], A[8:5], B[4:1], Cin[0]}
//   start, hold, clear  begin a pass, stall issue, synchronous flush
//   stop                (ALU_SEQ_LOOP_EN only) finish the current pass, then stop looping
//   A, B, Cin, Mode     registered op bus, holds the last issued op
//   op_valid            bus carries a newly issued op this cycle
//   busy, done          issuing / one-cycle end-of-run pulse
//   count, full, wr_err loaded entries, buffer full, sticky dropped-write flag
// Optional feature: define ALU_SEQ_LOOP_EN for continuous looping with a stop input.
module alu_op_sequencer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              wr_en,
    input  logic [12:0]       wr_data,
    input  logic              start,
    input  logic              hold,
    input  logic              clear,
`ifdef ALU_SEQ_LOOP_EN
    input  logic              stop,
`endif
    output logic [3:0]        A,
    output logic [3:0]        B,
    output logic              Cin,
    output logic [3:0]        Mode,
    output logic              op_valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              wr_err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    state_t            state, state_nxt;
    logic [12:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              last, wr_ok, go, issue, at_end, end_pass, stop_req;
    assign busy = state == RUN;
    assign done = state == DONE;
    assign full = count == FULL_CNT;
`ifdef ALU_SEQ_LOOP_EN
    logic stop_lat;
    // stop is remembered for the rest of the run; the pass only ends at its last entry
    always_ff @(posedge Clk or negedge nReset)
        if (!nReset) stop_lat <= 1'b0;
        else         stop_lat <= !clear && state == RUN && (stop_lat || stop);
    assign stop_req = stop_lat || stop;
`else
    assign stop_req = 1'b1;
`endif
    // last marks the cycle after the final op issued, so done follows that op by one cycle
    always_comb begin
        wr_ok     = wr_en && !full && state != RUN;
        go        = start && state == IDLE && (count != '0 || wr_ok);
        issue     = state == RUN && !last && !hold;
        at_end    = {1'b0, rd_ptr} == count - ONE;
        end_pass  = issue && at_end && stop_req;
        state_nxt = state == IDLE ? (go ? RUN : IDLE) :
                    state == RUN  ? (last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge Clk or negedge nReset)
        if (!nReset) begin
            state              <= IDLE;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            wr_err             <= 1'b0;
            last               <= 1'b0;
            op_valid           <= 1'b0;
            {Mode, A, B, Cin}  <= '0;
        end else if (clear) begin
            state              <= IDLE;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            wr_err             <= 1'b0;
            last               <= 1'b0;
            op_valid           <= 1'b0;
            {Mode, A, B, Cin}  <= '0;
        end else begin
            state    <= state_nxt;
            last     <= end_pass;
            op_valid <= issue;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                count  <= count + ONE;
            end
            if (wr_en && !wr_ok) wr_err <= 1'b1;
            if (go) rd_ptr <= '0;
            else if (issue) rd_ptr <= at_end ? '0 : rd_ptr + ADDR_W'(1);
            if (issue) {Mode, A, B, Cin} <= mem[rd_ptr];
        end
    always_ff @(posedge Clk)
        if (wr_ok && !clear) mem[wr_ptr] <= wr_data;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized self-checking bench with a queue-based reference model
module tb_alu_op_sequencer;
    localparam int DEPTH = 16;
`ifdef ALU_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif
    logic        Clk = 0, nReset = 0;
    logic        wr_en = 0, start = 0, hold = 0, clear = 0, stop = 0;
    logic [12:0] wr_data = '0;
    logic [3:0]  A, B, Mode;
    logic        Cin, op_valid, busy, done, full, wr_err;
    logic [4:0]  count;
    int          tests = 0, fails = 0;

    alu_op_sequencer #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
        .Clk(Clk), .nReset(nReset), .wr_en(wr_en), .wr_data(wr_data),
        .start(start), .hold(hold), .clear(clear),
`ifdef ALU_SEQ_LOOP_EN
        .stop(stop),
`endif
        .A(A), .B(B), .Cin(Cin), .Mode(Mode), .op_valid(op_valid),
        .busy(busy), .done(done), .count(count), .full(full), .wr_err(wr_err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the program is a queue; a run walks an index through it.
    logic [12:0] prog[$];
    bit          m_run, m_fin, m_dn, m_ov, m_err, m_stop;
    int          m_idx;
    logic [12:0] m_op;
    always @(posedge Clk or negedge nReset) begin : model
        bit nd;
        nd = 0;
        if (!nReset || clear) begin
            prog.delete();
            m_run = 0; m_fin = 0; m_dn = 0; m_ov = 0; m_err = 0; m_stop = 0; m_idx = 0; m_op = '0;
        end else begin
            m_ov = 0;
            if (m_run) begin
                if (wr_en) m_err = 1;
                if (m_fin) begin
                    m_run = 0;
                    nd = 1;
                end else begin
                    if (stop) m_stop = 1;
                    if (!hold) begin
                        m_ov = 1;
                        m_op = prog[m_idx];
                        m_idx++;
                        if (m_idx == prog.size()) begin
                            if (!LOOP || m_stop) m_fin = 1;
                            else m_idx = 0;
                        end
                    end
                end
            end else begin
                if (wr_en) begin
                    if (prog.size() == DEPTH) m_err = 1;
                    else prog.push_back(wr_data);
                end
                if (start && !m_dn && prog.size() != 0) begin
                    m_run = 1; m_fin = 0; m_idx = 0; m_stop = 0;
                end
            end
            m_dn = nd;
        end
    end

    always @(negedge Clk) begin
        chk("op_valid", 32'(op_valid), 32'(m_ov));
        chk("op_bus", 32'({Mode, A, B, Cin}), 32'(m_op));
        chk("busy", 32'(busy), 32'(m_run));
        chk("done", 32'(done), 32'(m_dn));
        chk("count", 32'(count), prog.size());
        chk("full", 32'(full), 32'(prog.size() == DEPTH));
        chk("wr_err", 32'(wr_err), 32'(m_err));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    task automatic load(input logic [12:0] d);
        wr_en = 1; wr_data = d;
        tick(1);
        wr_en = 0;
    endtask

    task automatic op_is(input string nm, input logic v, input logic [12:0] w);
        chk({nm, "_valid"}, 32'(op_valid), 32'(v));
        chk(nm, 32'({Mode, A, B, Cin}), 32'(w));
    endtask

    initial begin
        #12;
        chk("rst_bus", 32'({Mode, A, B, Cin}), 0);
        chk("rst_flags", 32'({op_valid, busy, done, full, wr_err}), 0);
        chk("rst_count", 32'(count), 0);
        @(posedge Clk); #2; nReset = 1;
        tick(1);

        load(13'h01FC); load(13'h033B); load(13'h1F4B);
        chk("t2_count", 32'(count), 3);
        start = 1; tick(1); start = 0;
        chk("t2_lat_busy", 32'(busy), 1);
        op_is("t2_lat", 0, 13'h0000);
        tick(1); op_is("t2_op0", 1, 13'h01FC);
        tick(1); op_is("t2_op1", 1, 13'h033B);
        tick(1); op_is("t2_op2", 1, 13'h1F4B);
        tick(1); op_is("t2_end", 0, 13'h1F4B);
        chk("t2_done", 32'({done, busy}), 32'h2);
        tick(1); chk("t2_done_once", 32'(done), 0);

        start = 1; tick(1); start = 0;
        tick(1); op_is("t3_op0", 1, 13'h01FC);
        hold = 1;
        tick(1); op_is("t3_hold1", 0, 13'h01FC);
        tick(1); op_is("t3_hold2", 0, 13'h01FC);
        hold = 0;
        tick(1); op_is("t3_op1", 1, 13'h033B);
        tick(1); op_is("t3_op2", 1, 13'h1F4B);
        chk("t3_no_done_yet", 32'(done), 0);
        tick(1); chk("t3_done", 32'(done), 1);
        tick(1);

        start = 1; tick(1); start = 0;
        tick(1);
        wr_en = 1; wr_data = 13'h0123; tick(1); wr_en = 0;
        chk("t4_run_wr_err", 32'(wr_err), 1);
        chk("t4_run_count", 32'(count), 3);
        tick(4);
        clear = 1; tick(1); clear = 0;
        chk("t4_clear_err", 32'({wr_err, count}), 0);
        for (int i = 0; i < 17; i++) begin
            load(13'($urandom));
            if (i == 15) chk("t4_full16", 32'({wr_err, full, count}), 32'h30);
        end
        chk("t4_overflow", 32'({wr_err, full, count}), 32'h70);

        clear = 1; tick(1); clear = 0;
        load(13'h01FC); load(13'h033B); load(13'h1F4B);
        start = 1; tick(1); start = 0;
        tick(2); op_is("t5_op1", 1, 13'h033B);
        clear = 1; tick(1); clear = 0;
        op_is("t5_clear", 0, 13'h0000);
        chk("t5_clear_st", 32'({busy, done, count}), 0);
        tick(1); chk("t5_no_done", 32'(done), 0);
        load(13'h01FC); load(13'h033B);
        start = 1; tick(1); start = 0;
        tick(1);
        nReset = 0; #1;
        op_is("t5_rst", 0, 13'h0000);
        chk("t5_rst_st", 32'({busy, done, count}), 0);
        tick(1); nReset = 1; tick(1);

`ifdef ALU_SEQ_LOOP_EN
        load(13'h0AAA); load(13'h1555);
        start = 1; tick(1); start = 0;
        tick(1); op_is("t6_op0", 1, 13'h0AAA);
        tick(1); op_is("t6_op1", 1, 13'h1555);
        tick(1); op_is("t6_op2", 1, 13'h0AAA);
        stop = 1;
        tick(1); stop = 0; op_is("t6_op3", 1, 13'h1555);
        chk("t6_no_done", 32'(done), 0);
        tick(1); op_is("t6_end", 0, 13'h1555);
        chk("t6_done", 32'(done), 1);
        tick(1); chk("t6_done_once", 32'(done), 0);
`endif

        for (int c = 0; c < 3000; c++) begin
            wr_en   = $urandom_range(0, 9) < 3;
            wr_data = 13'($urandom);
            start   = $urandom_range(0, 9) == 0;
            hold    = $urandom_range(0, 3) == 0;
            clear   = $urandom_range(0, 99) == 0;
            stop    = LOOP && $urandom_range(0, 29) == 0;
            if ($urandom_range(0, 299) == 0) nReset = 0;
            tick(1);
            nReset = 1;
        end
        {wr_en, start, hold, clear, stop} = '0;
        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
